// File: rtl/simon_pkg.sv
// Shared constants and word helpers for the SIMON 32/64 datapath and key schedule.
package simon_pkg;

  localparam int N_DEF = 16;
  localparam int M_DEF = 4;
  localparam int T_DEF = 32;
  localparam int WMAX  = 64;

  // z0 stored LSB-first: bit j is the j-th element of the z0 sequence.
  localparam logic [61:0] Z0 = 62'h19C3522FB386A45F;

  function automatic logic [WMAX-1:0] rol(input logic [WMAX-1:0] v, input int s, input int w);
    logic [WMAX-1:0] m;
    m = (WMAX'(1) << w) - WMAX'(1);
    return ((v << s) | (v >> (w - s))) & m;
  endfunction

  function automatic logic [WMAX-1:0] ror(input logic [WMAX-1:0] v, input int s, input int w);
    return rol(v, w - s, w);
  endfunction

  function automatic logic [WMAX-1:0] f(input logic [WMAX-1:0] v, input int w);
    return (rol(v, 1, w) & rol(v, 8, w)) ^ rol(v, 2, w);
  endfunction

endpackage

// File: rtl/simon_key_expand.sv
// Combinational SIMON key schedule step: derives rk[i] from rk[i-1], rk[i-3], rk[i-M].
module simon_key_expand
  import simon_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic [N-1:0] rkPrev_i,
  input  logic [N-1:0] rkPrev3_i,
  input  logic [N-1:0] rkPrevM_i,
  input  logic         zBit_i,
  output logic [N-1:0] rkNext_o
);

  function automatic logic [N-1:0] expandWord(input logic [N-1:0] p1, input logic [N-1:0] p3,
                                              input logic [N-1:0] pm, input logic z);
    logic [WMAX-1:0] t;
    t = ror(WMAX'(p1), 3, N);
    if (M == 4) t = t ^ WMAX'(p3);
    t = t ^ ror(t, 1, N);
    return ~pm ^ t[N-1:0] ^ N'(z) ^ N'(3);
  endfunction

  always_comb begin
    rkNext_o = expandWord(rkPrev_i, rkPrev3_i, rkPrevM_i, zBit_i);
  end

endmodule

// File: rtl/simon_datapath_1.sv
// SIMON round datapath with round-key store; one round per cycle under controller strobes.
// Define SIMON_DEC_EN to enable the decrypt round (enc_dec=1); otherwise every round encrypts.
module simon_datapath_1
  import simon_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int T = T_DEF
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           enc_dec,
  input  logic [5:0]     count,
  input  logic           kLd,
  input  logic           kExp,
  input  logic           pLd,
  input  logic           rEn,
  input  logic [2*N-1:0] plain,
  input  logic [M*N-1:0] key,
  output logic [2*N-1:0] cipher,
  output logic           oValid
);

  localparam int IW = (T > 1) ? $clog2(T) : 1;

  logic [N-1:0]  rk_q [T];
  logic [N-1:0]  x_q, y_q, x_d, y_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx;
  logic          inRange, expOk, blockLd, roundEn, decRound;
  logic [5:0]    zRaw, zIdx;
  logic [N-1:0]  keyNext, rkCur;

  function automatic logic [N-1:0] fN(input logic [N-1:0] v);
    logic [WMAX-1:0] w;
    w = f(WMAX'(v), N);
    return w[N-1:0];
  endfunction

  assign idx     = count[IW-1:0];
  assign inRange = int'(count) < T;
  assign rkCur   = rk_q[idx];

  // kLd outranks kExp, but a block load alongside a key load still lands.
  assign expOk   = kExp && !kLd && inRange && (int'(count) >= M);
  assign blockLd = pLd && (kLd || !kExp);
  assign roundEn = rEn && !kLd && !kExp && !pLd && inRange;

`ifdef SIMON_DEC_EN
  assign decRound = enc_dec;
`else
  logic unusedEncDec;
  assign unusedEncDec = enc_dec;
  assign decRound     = 1'b0;
`endif

  assign zRaw = count - 6'(M);
  assign zIdx = (zRaw >= 6'd62) ? zRaw - 6'd62 : zRaw;

  simon_key_expand #(.N(N), .M(M)) u_keyExpand (
    .rkPrev_i  (rk_q[idx - IW'(1)]),
    .rkPrev3_i (rk_q[idx - IW'(3)]),
    .rkPrevM_i (rk_q[idx - IW'(M)]),
    .zBit_i    (Z0[zIdx]),
    .rkNext_o  (keyNext)
  );

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    if (blockLd) begin
      x_d     = plain[2*N-1:N];
      y_d     = plain[N-1:0];
      valid_d = 1'b0;
    end else if (roundEn) begin
      if (decRound) begin
        y_d = x_q ^ fN(y_q) ^ rkCur;
        x_d = y_q;
        if (count == 6'd0) valid_d = 1'b1;
      end else begin
        x_d = y_q ^ fN(x_q) ^ rkCur;
        y_d = x_q;
        if (int'(count) == T - 1) valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < T; i++) rk_q[i] <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      if (kLd) begin
        for (int i = 0; i < M; i++) rk_q[i] <= key[i*N +: N];
      end else if (expOk) begin
        rk_q[idx] <= keyNext;
      end
    end
  end

  assign cipher = {x_q, y_q};
  assign oValid = valid_q;

endmodule
